// File: rtl/prepare_eng_ctrl_pipe.sv
// rtl/prepare_eng_ctrl_pipe.sv - control FSM for the VR PREPARE engine with pipelined log writes
//
// Purpose:
//   Accepts PREPARE metadata/request from the manage stage, checks view/op order and log
//   space, starts in-order prepares into the log and answers each with a multi-beat
//   PREPAREOK to UDP. Stale prepares are dropped. Up to MAX_INFLIGHT log writes may be
//   outstanding; SYNC_REPLY holds the reply until every outstanding write is durable.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   manage_prep_msg_val/req_val     metadata valid / request data available
//   prep_manage_msg_rdy             metadata accept pulse
//   ctrl_datap_store_info           datapath latches metadata (in READY)
//   datap_ctrl_prep_ok/log_has_space  order check and log space from datapath
//   prep_vr_state_wr_req            op-num update pulse
//   start_req_ingest                log write start pulse
//   log_write_done                  one pulse per completed log write
//   drop_req / drop_done            request discard handshake
//   prep_to_udp_meta_val / to_udp_prep_meta_rdy   PREPAREOK metadata handshake
//   prep_to_udp_data_val/_last, prep_beat_idx, to_udp_prep_data_rdy   PREPAREOK data beats
//   inflight_cnt                    outstanding log writes
//   prep_engine_rdy / prep_engine_idle            engine status

module prepare_eng_ctrl_pipe #(
   parameter int  PREPOK_BEATS = 2,
   parameter int  MAX_INFLIGHT = 4,
   parameter bit  SYNC_REPLY   = 1'b0,
   localparam int BEAT_W       = (PREPOK_BEATS > 1) ? $clog2(PREPOK_BEATS) : 1,
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              manage_prep_msg_val,
   output logic              prep_manage_msg_rdy,
   input  logic              manage_prep_req_val,
   output logic              ctrl_datap_store_info,
   input  logic              datap_ctrl_prep_ok,
   input  logic              datap_ctrl_log_has_space,
   output logic              prep_vr_state_wr_req,
   output logic              start_req_ingest,
   input  logic              log_write_done,
   output logic              drop_req,
   input  logic              drop_done,
   output logic              prep_to_udp_meta_val,
   input  logic              to_udp_prep_meta_rdy,
   output logic              prep_to_udp_data_val,
   output logic              prep_to_udp_data_last,
   output logic [BEAT_W-1:0] prep_beat_idx,
   input  logic              to_udp_prep_data_rdy,
   output logic [CNT_W-1:0]  inflight_cnt,
   output logic              prep_engine_rdy,
   output logic              prep_engine_idle
);

   typedef enum logic [2:0] {
      S_READY,
      S_HANDLE_OP,
      S_WAIT_SPACE,
      S_WAIT_LOG,
      S_SEND_META,
      S_SEND_DATA,
      S_DROP
   } state_t;

   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INFLIGHT);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PREPOK_BEATS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [BEAT_W-1:0] beat;
   logic [CNT_W-1:0]  cnt;
   logic              can_accept;
   logic              done_eff;
   logic              last_beat;

   assign can_accept = (cnt < MAX_CNT);
   // A completion with nothing outstanding (e.g. a write started before reset) is ignored.
   assign done_eff   = log_write_done && (cnt != '0);
   assign last_beat  = (beat == LAST_BEAT);

   always_comb begin
      state_nxt             = state;
      prep_manage_msg_rdy   = 1'b0;
      ctrl_datap_store_info = 1'b0;
      prep_vr_state_wr_req  = 1'b0;
      start_req_ingest      = 1'b0;
      drop_req              = 1'b0;
      prep_to_udp_meta_val  = 1'b0;
      prep_to_udp_data_val  = 1'b0;
      case (state)
         S_READY: begin
            ctrl_datap_store_info = 1'b1;
            if (manage_prep_msg_val && manage_prep_req_val && can_accept) begin
               prep_manage_msg_rdy = 1'b1;
               state_nxt           = S_HANDLE_OP;
            end
         end
         S_HANDLE_OP, S_WAIT_SPACE: begin
            if ((state == S_HANDLE_OP) && !datap_ctrl_prep_ok) begin
               state_nxt = S_DROP;
            end else if (!datap_ctrl_log_has_space) begin
               state_nxt = S_WAIT_SPACE;
            end else begin
               prep_vr_state_wr_req = 1'b1;
               start_req_ingest     = 1'b1;
               state_nxt            = SYNC_REPLY ? S_WAIT_LOG : S_SEND_META;
            end
         end
         S_WAIT_LOG: begin
            // The count already includes the write started for this prepare.
            if (cnt == '0) state_nxt = S_SEND_META;
         end
         S_SEND_META: begin
            prep_to_udp_meta_val = 1'b1;
            if (to_udp_prep_meta_rdy) state_nxt = S_SEND_DATA;
         end
         S_SEND_DATA: begin
            prep_to_udp_data_val = 1'b1;
            if (to_udp_prep_data_rdy && last_beat) state_nxt = S_READY;
         end
         S_DROP: begin
            drop_req = 1'b1;
            if (drop_done) state_nxt = S_READY;
         end
         default: state_nxt = S_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_READY;
         beat  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         case ({start_req_ingest, done_eff})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (state == S_SEND_META) begin
            beat <= '0;
         end else if ((state == S_SEND_DATA) && to_udp_prep_data_rdy) begin
            beat <= last_beat ? '0 : beat + BEAT_W'(1);
         end
      end
   end

   assign prep_to_udp_data_last = (state == S_SEND_DATA) && last_beat;
   assign prep_beat_idx         = beat;
   assign inflight_cnt          = cnt;
   assign prep_engine_rdy       = (state == S_READY) && can_accept;
   assign prep_engine_idle      = (state == S_READY) && (cnt == '0);

endmodule

// File: tb/tb_prepare_eng_ctrl_pipe.sv
// tb/tb_prepare_eng_ctrl_pipe.sv - self-checking bench for prepare_eng_ctrl_pipe

module tb_prepare_eng_ctrl_pipe;

   localparam int BEATS = 2;
   localparam int MAXF  = 4;

   localparam int PH_IDLE  = 0;
   localparam int PH_ACC   = 1;
   localparam int PH_NONE  = 2;
   localparam int PH_START = 3;
   localparam int PH_DROP  = 4;
   localparam int PH_META  = 5;
   localparam int PH_DATA  = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic msg_val, req_val, prep_ok, has_space, wdone, drop_done, meta_rdy, data_rdy;

   logic       msg_rdy, store_info, wr_req, start, drop_req, meta_val, data_val, data_last;
   logic       engine_rdy, engine_idle;
   logic [0:0] beat_idx;
   logic [2:0] inflight;

   logic       s_msg_rdy, s_store_info, s_wr_req, s_start, s_drop_req, s_meta_val, s_data_val, s_data_last;
   logic       s_engine_rdy, s_engine_idle;
   logic [0:0] s_beat_idx;
   logic [2:0] s_inflight;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prepare_eng_ctrl_pipe #(.PREPOK_BEATS(BEATS), .MAX_INFLIGHT(MAXF), .SYNC_REPLY(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .manage_prep_msg_val(msg_val), .prep_manage_msg_rdy(msg_rdy),
      .manage_prep_req_val(req_val), .ctrl_datap_store_info(store_info),
      .datap_ctrl_prep_ok(prep_ok), .datap_ctrl_log_has_space(has_space),
      .prep_vr_state_wr_req(wr_req), .start_req_ingest(start),
      .log_write_done(wdone), .drop_req(drop_req), .drop_done(drop_done),
      .prep_to_udp_meta_val(meta_val), .to_udp_prep_meta_rdy(meta_rdy),
      .prep_to_udp_data_val(data_val), .prep_to_udp_data_last(data_last),
      .prep_beat_idx(beat_idx), .to_udp_prep_data_rdy(data_rdy),
      .inflight_cnt(inflight), .prep_engine_rdy(engine_rdy), .prep_engine_idle(engine_idle)
   );

   prepare_eng_ctrl_pipe #(.PREPOK_BEATS(BEATS), .MAX_INFLIGHT(MAXF), .SYNC_REPLY(1'b1)) dut_sync (
      .clk(clk), .rst_n(rst_n),
      .manage_prep_msg_val(msg_val), .prep_manage_msg_rdy(s_msg_rdy),
      .manage_prep_req_val(req_val), .ctrl_datap_store_info(s_store_info),
      .datap_ctrl_prep_ok(prep_ok), .datap_ctrl_log_has_space(has_space),
      .prep_vr_state_wr_req(s_wr_req), .start_req_ingest(s_start),
      .log_write_done(wdone), .drop_req(s_drop_req), .drop_done(drop_done),
      .prep_to_udp_meta_val(s_meta_val), .to_udp_prep_meta_rdy(meta_rdy),
      .prep_to_udp_data_val(s_data_val), .prep_to_udp_data_last(s_data_last),
      .prep_beat_idx(s_beat_idx), .to_udp_prep_data_rdy(data_rdy),
      .inflight_cnt(s_inflight), .prep_engine_rdy(s_engine_rdy), .prep_engine_idle(s_engine_idle)
   );

   // Output vector order: msg_rdy store wr start drop meta data last idx
   function automatic logic [8:0] obs0();
      return {msg_rdy, store_info, wr_req, start, drop_req, meta_val, data_val, data_last, beat_idx};
   endfunction

   function automatic logic [8:0] obs1();
      return {s_msg_rdy, s_store_info, s_wr_req, s_start, s_drop_req, s_meta_val, s_data_val,
              s_data_last, s_beat_idx};
   endfunction

   // Expected outputs for one cycle of a given message phase.
   function automatic logic [8:0] ev(input int ph, input int idx);
      logic [8:0] v;
      v = '0;
      case (ph)
         PH_IDLE:  v[7] = 1'b1;
         PH_ACC:   begin v[8] = 1'b1; v[7] = 1'b1; end
         PH_START: begin v[6] = 1'b1; v[5] = 1'b1; end
         PH_DROP:  v[4] = 1'b1;
         PH_META:  v[3] = 1'b1;
         PH_DATA:  begin v[2] = 1'b1; v[1] = (idx == BEATS - 1); v[0] = idx[0]; end
         default:  v = '0;
      endcase
      return v;
   endfunction

   // Phase k of a prepare that is accepted, started at once and fully ready downstream.
   function automatic int seq_ph(input int k);
      case (k)
         0: return PH_ACC;
         1: return PH_START;
         2: return PH_META;
         default: return PH_DATA;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; msg_val = 1'b0; req_val = 1'b0; prep_ok = 1'b1; has_space = 1'b1;
      wdone = 1'b0; drop_done = 1'b0; meta_rdy = 1'b1; data_rdy = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (obs0() !== ev(PH_IDLE, 0)) begin failures++; $display("FAIL reset_outs got=%b exp=%b", obs0(), ev(PH_IDLE, 0)); end
      checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", inflight); end
      checks++; if ({engine_rdy, engine_idle} !== 2'b11) begin failures++; $display("FAIL reset_status got=%b exp=11", {engine_rdy, engine_idle}); end
      checks++; if (obs1() !== ev(PH_IDLE, 0)) begin failures++; $display("FAIL reset_sync_outs got=%b exp=%b", obs1(), ev(PH_IDLE, 0)); end
      checks++; if (s_inflight !== 3'd0) begin failures++; $display("FAIL reset_sync_cnt got=%0d exp=0", s_inflight); end
   endtask

   task automatic test_single();
      int m = 0;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         int p, i;
         logic [1:0] er;
         p = (c < 5) ? seq_ph(c) : PH_IDLE;
         i = (c == 4) ? 1 : 0;
         msg_val = (c == 0); req_val = (c == 0);
         wdone = (c == 6);
         #1;
         er = {(p <= PH_ACC) && (m < MAXF), (p <= PH_ACC) && (m == 0)};
         checks++; if (obs0() !== ev(p, i)) begin failures++; $display("FAIL single_outs c=%0d got=%b exp=%b", c, obs0(), ev(p, i)); end
         checks++; if (inflight !== 3'(m)) begin failures++; $display("FAIL single_cnt c=%0d got=%0d exp=%0d", c, inflight, m); end
         checks++; if ({engine_rdy, engine_idle} !== er) begin failures++; $display("FAIL single_status c=%0d got=%b exp=%b", c, {engine_rdy, engine_idle}, er); end
         if (p == PH_START) m++;
         if (wdone && m > 0) m--;
         step();
      end
   endtask

   task automatic test_backpressure();
      int m = 0;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         int p, i;
         bit dec;
         logic [1:0] er;
         if (c < 20)      begin p = seq_ph(c % 5);  i = (c % 5 == 4) ? 1 : 0; end
         else if (c < 24) begin p = PH_IDLE;        i = 0; end
         else if (c < 29) begin p = seq_ph(c - 24); i = (c == 28) ? 1 : 0; end
         else             begin p = PH_IDLE;        i = 0; end
         msg_val = (c <= 24); req_val = (c <= 24);
         wdone = (c == 23);
         #1;
         er = {(p <= PH_ACC) && (m < MAXF), (p <= PH_ACC) && (m == 0)};
         checks++; if (obs0() !== ev(p, i)) begin failures++; $display("FAIL bp_outs c=%0d got=%b exp=%b", c, obs0(), ev(p, i)); end
         checks++; if (inflight !== 3'(m)) begin failures++; $display("FAIL bp_cnt c=%0d got=%0d exp=%0d", c, inflight, m); end
         checks++; if ({engine_rdy, engine_idle} !== er) begin failures++; $display("FAIL bp_status c=%0d got=%b exp=%b", c, {engine_rdy, engine_idle}, er); end
         dec = wdone && (m > 0);
         if (p == PH_START) m++;
         if (dec) m--;
         step();
      end
   endtask

   task automatic test_back_to_back();
      int m = 0;
      do_reset();
      for (int c = 0; c < 19; c++) begin
         int p, i;
         bit dec;
         if (c < 15) begin p = seq_ph(c % 5); i = (c % 5 == 4) ? 1 : 0; end
         else        begin p = PH_IDLE;       i = 0; end
         msg_val = (c <= 10); req_val = (c <= 10);
         wdone = (c == 11) || (c >= 15 && c <= 17);
         #1;
         checks++; if (obs0() !== ev(p, i)) begin failures++; $display("FAIL b2b_outs c=%0d got=%b exp=%b", c, obs0(), ev(p, i)); end
         checks++; if (inflight !== 3'(m)) begin failures++; $display("FAIL b2b_cnt c=%0d got=%0d exp=%0d", c, inflight, m); end
         dec = wdone && (m > 0);
         if (p == PH_START) m++;
         if (dec) m--;
         step();
      end
   endtask

   task automatic test_drop();
      do_reset();
      prep_ok = 1'b0;
      for (int c = 0; c < 7; c++) begin
         int p;
         p = (c == 0) ? PH_ACC : (c == 1) ? PH_NONE : (c <= 4) ? PH_DROP : PH_IDLE;
         msg_val = (c == 0); req_val = (c == 0);
         drop_done = (c == 4);
         #1;
         checks++; if (obs0() !== ev(p, 0)) begin failures++; $display("FAIL drop_outs c=%0d got=%b exp=%b", c, obs0(), ev(p, 0)); end
         checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL drop_cnt c=%0d got=%0d exp=0", c, inflight); end
         step();
      end
      prep_ok = 1'b1;
   endtask

   task automatic test_space_sync();
      int m = 0;
      do_reset();
      for (int c = 0; c < 15; c++) begin
         int p0, p1, i0, i1;
         bit dec;
         p0 = (c == 0) ? PH_ACC : (c < 6) ? PH_NONE : (c == 6) ? PH_START :
              (c == 7) ? PH_META : (c < 10) ? PH_DATA : PH_IDLE;
         p1 = (c == 0) ? PH_ACC : (c < 6) ? PH_NONE : (c == 6) ? PH_START :
              (c < 11) ? PH_NONE : (c == 11) ? PH_META : (c < 14) ? PH_DATA : PH_IDLE;
         i0 = (c == 9) ? 1 : 0;
         i1 = (c == 13) ? 1 : 0;
         msg_val = (c == 0); req_val = (c == 0);
         has_space = (c == 0) || (c >= 6);
         wdone = (c == 9);
         #1;
         checks++; if (obs0() !== ev(p0, i0)) begin failures++; $display("FAIL space_outs c=%0d got=%b exp=%b", c, obs0(), ev(p0, i0)); end
         checks++; if (obs1() !== ev(p1, i1)) begin failures++; $display("FAIL sync_outs c=%0d got=%b exp=%b", c, obs1(), ev(p1, i1)); end
         checks++; if (inflight !== 3'(m)) begin failures++; $display("FAIL space_cnt c=%0d got=%0d exp=%0d", c, inflight, m); end
         checks++; if (s_inflight !== 3'(m)) begin failures++; $display("FAIL sync_cnt c=%0d got=%0d exp=%0d", c, s_inflight, m); end
         dec = wdone && (m > 0);
         if (p0 == PH_START) m++;
         if (dec) m--;
         step();
      end
   endtask

   task automatic test_stall_reset();
      int m = 0;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         int p, i;
         logic [1:0] er;
         p = (c < 3) ? seq_ph(c) : (c <= 7) ? PH_DATA : PH_IDLE;
         i = (c == 7) ? 1 : 0;
         msg_val = (c == 0); req_val = (c == 0);
         data_rdy = !(c >= 3 && c <= 5);
         rst_n = (c != 7);
         wdone = (c == 8);
         #1;
         if (c != 7) begin
            er = {(p <= PH_ACC) && (m < MAXF), (p <= PH_ACC) && (m == 0)};
            checks++; if (obs0() !== ev(p, i)) begin failures++; $display("FAIL stall_outs c=%0d got=%b exp=%b", c, obs0(), ev(p, i)); end
            checks++; if (inflight !== 3'(m)) begin failures++; $display("FAIL stall_cnt c=%0d got=%0d exp=%0d", c, inflight, m); end
            checks++; if ({engine_rdy, engine_idle} !== er) begin failures++; $display("FAIL stall_status c=%0d got=%b exp=%b", c, {engine_rdy, engine_idle}, er); end
         end
         if (p == PH_START) m++;
         if (c == 7) m = 0;
         else if (wdone && m > 0) m--;
         step();
      end
      rst_n = 1'b1;
      data_rdy = 1'b1;
   endtask

   // Each prepare is expanded into its expected phase sequence (phase*4 + beat*2 + handshake)
   // from randomly chosen stall lengths; completions arrive randomly while writes are open.
   task automatic test_random();
      int q[$];
      int m = 0;
      do_reset();
      for (int t = 0; t < 30; t++) begin
         bit ok;
         int sw, mw, dw, ds;
         ok = ($urandom_range(0, 3) != 0);
         q = {};
         if ($urandom_range(0, 2) == 0) q.push_back(PH_IDLE * 4);
         q.push_back(PH_ACC * 4);
         if (!ok) begin
            q.push_back(PH_NONE * 4);
            dw = $urandom_range(0, 2);
            for (int k = 0; k <= dw; k++) q.push_back(PH_DROP * 4 + ((k == dw) ? 1 : 0));
         end else begin
            sw = $urandom_range(0, 3);
            for (int k = 0; k < sw; k++) q.push_back(PH_NONE * 4);
            q.push_back(PH_START * 4);
            mw = $urandom_range(0, 2);
            for (int k = 0; k <= mw; k++) q.push_back(PH_META * 4 + ((k == mw) ? 1 : 0));
            for (int b = 0; b < BEATS; b++) begin
               ds = $urandom_range(0, 2);
               for (int k = 0; k <= ds; k++) q.push_back(PH_DATA * 4 + b * 2 + ((k == ds) ? 1 : 0));
            end
         end
         while (q.size() > 0) begin
            int p, i;
            bit hs, blocked, dec;
            logic [8:0] e;
            logic [1:0] er;
            p  = q[0] / 4;
            i  = (q[0] / 2) % 2;
            hs = (q[0] % 2) == 1;
            blocked = (p == PH_ACC) && (m == MAXF);
            msg_val = (p == PH_ACC); req_val = (p == PH_ACC);
            prep_ok = ok;
            has_space = (p != PH_NONE);
            meta_rdy  = (p == PH_META) && hs;
            data_rdy  = (p == PH_DATA) && hs;
            drop_done = (p == PH_DROP) && hs;
            wdone = blocked || ((m > 0) && ($urandom_range(0, 2) == 0));
            #1;
            e  = blocked ? ev(PH_IDLE, 0) : ev(p, i);
            er = {(p <= PH_ACC) && (m < MAXF), (p <= PH_ACC) && (m == 0)};
            checks++; if (obs0() !== e) begin failures++; $display("FAIL rand_outs t=%0d ph=%0d got=%b exp=%b", t, p, obs0(), e); end
            checks++; if (inflight !== 3'(m)) begin failures++; $display("FAIL rand_cnt t=%0d ph=%0d got=%0d exp=%0d", t, p, inflight, m); end
            checks++; if ({engine_rdy, engine_idle} !== er) begin failures++; $display("FAIL rand_status t=%0d ph=%0d got=%b exp=%b", t, p, {engine_rdy, engine_idle}, er); end
            if (!blocked) void'(q.pop_front());
            dec = wdone && (m > 0);
            if (p == PH_START) m++;
            if (dec) m--;
            step();
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_drop();
      test_space_sync();
      test_stall_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
